pi_controller_aw: RTL and testbench

//   Parametrised fixed-point PI controller; next generation of the single-channel PI loop block.

---
 rtl/pi_controller_aw.sv | 132 +++++++++++++
 tb/tb_pi_controller_aw.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pi_controller_aw.sv
// ---------------------------------------------------------------------------
// pi_controller_aw
//   Fixed-point PI controller with runtime gains, a 2-stage pipeline,
//   integrator clamping, conditional-integration anti-windup, output
//   saturation and integrator clear/hold. Placed between the error generator
//   (setpoint - measurement) and the actuator driver.
//
//   Stage 1 registers the proportional and integral products of each valid
//   error sample. Stage 2 updates the integrator and produces the saturated
//   output, so out_valid follows in_valid by exactly two clock edges.
//
// Ports
//   clk        clock
//   rst        synchronous, active-high reset
//   in_valid   error sample valid this cycle
//   error      signed error sample (DW)
//   kp, ki     unsigned gains, Q.FRAC (GW), sampled with in_valid
//   int_clear  zero the integrator (wins over int_hold and the stage-2 update)
//   int_hold   freeze the integrator; output is still computed
//   out_valid  out is valid this cycle
//   out        signed saturated control output (DW)
//   sat_hi     out clipped to +max (qualified by out_valid)
//   sat_lo     out clipped to -max (qualified by out_valid)
//   int_sat    integrator sits at +INT_LIM or -INT_LIM (level)
// ---------------------------------------------------------------------------
module pi_controller_aw #(
  parameter int     DW      = 16,
  parameter int     GW      = 16,
  parameter int     AW      = 40,  // must be >= DW+GW+1
  parameter int     FRAC    = 8,
  parameter longint INT_LIM = (longint'(1) << (AW - 2)) - 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] error,
  input  logic        [GW-1:0] kp,
  input  logic        [GW-1:0] ki,
  input  logic                 int_clear,
  input  logic                 int_hold,
  output logic                 out_valid,
  output logic signed [DW-1:0] out,
  output logic                 sat_hi,
  output logic                 sat_lo,
  output logic                 int_sat
);

  localparam int PW = DW + GW + 1;  // full-precision product width

  // Limits are held one bit wider than the integrator so that the unclamped
  // sum integ + i can be compared without overflowing.
  localparam logic signed [AW:0]   LIM_P   = (AW+1)'(INT_LIM);
  localparam logic signed [AW:0]   LIM_N   = -LIM_P;
  localparam logic signed [AW:0]   Y_MAX   = (AW+1)'((longint'(1) << (DW - 1)) - 1);
  localparam logic signed [AW:0]   Y_MIN   = -Y_MAX - 1;
  localparam logic signed [DW-1:0] OUT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] OUT_MIN = {1'b1, {(DW-1){1'b0}}};

  logic signed [PW-1:0] p_full, i_full;
  logic signed [AW-1:0] p_r, i_r, integ;
  logic                 v1;

  // Gains are zero-extended so they stay positive in the signed product.
  assign p_full = PW'(error) * PW'($signed({1'b0, kp}));
  assign i_full = PW'(error) * PW'($signed({1'b0, ki}));

  // Stage-2 datapath
  logic signed [AW:0]   acc, sum, y;
  logic signed [AW-1:0] cand, integ_new;
  logic                 i_pos, i_neg, blocked, y_hi, y_lo;

  always_comb begin
    // NOTE: every always_comb output gets a value on every path (here by
    // straight-line assignment first), otherwise a latch is inferred.
    acc = (AW+1)'(integ) + (AW+1)'(i_r);
    if (acc > LIM_P)      cand = LIM_P[AW-1:0];
    else if (acc < LIM_N) cand = LIM_N[AW-1:0];
    else                  cand = acc[AW-1:0];

    // Anti-windup: stop pushing the integrator further into a saturation
    // that the previous output already hit.
    i_neg   = i_r[AW-1];
    i_pos   = !i_r[AW-1] && (i_r != '0);
    blocked = int_hold || (sat_hi && i_pos) || (sat_lo && i_neg);

    if (int_clear)    integ_new = '0;
    else if (blocked) integ_new = integ;
    else              integ_new = cand;

    // Arithmetic shift gives floor rounding on the Q.FRAC sum.
    sum  = (AW+1)'(p_r) + (AW+1)'(integ_new);
    y    = sum >>> FRAC;
    y_hi = (y > Y_MAX);
    y_lo = (y < Y_MIN);
  end

  assign int_sat = ((AW+1)'(integ) == LIM_P) || ((AW+1)'(integ) == LIM_N);

  // NOTE: clocked state is assigned with <= so every register samples the
  // pre-edge values; blocking = here would create ordering-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      p_r       <= '0;
      i_r       <= '0;
      integ     <= '0;
      out_valid <= 1'b0;
      out       <= '0;
      sat_hi    <= 1'b0;
      sat_lo    <= 1'b0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        p_r <= AW'(p_full);
        i_r <= AW'(i_full);
      end

      out_valid <= v1;
      if (v1) begin
        sat_hi <= y_hi;
        sat_lo <= y_lo;
        if (y_hi)      out <= OUT_MAX;
        else if (y_lo) out <= OUT_MIN;
        else           out <= y[DW-1:0];
      end

      // A clear acts even without a sample in stage 2; integ_new is 0 then.
      if (int_clear || v1) integ <= integ_new;
    end
  end

endmodule

// File: tb/tb_pi_controller_aw.sv
// ---------------------------------------------------------------------------
// tb_pi_controller_aw
//   Drives two controllers (default INT_LIM and INT_LIM=1000) with the same
//   stimulus and compares every cycle against a plain-arithmetic model that
//   treats each sample as: product now, integrate-and-output one edge later.
// ---------------------------------------------------------------------------
module tb_pi_controller_aw;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic signed [15:0]  error = '0;
  logic        [15:0]  kp = '0, ki = '0;
  logic                int_clear = 1'b0, int_hold = 1'b0;

  logic                ov [2];
  logic signed [15:0]  o  [2];
  logic                shi[2], slo[2], isat[2];

  always #5 clk = ~clk;

  pi_controller_aw dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .error(error), .kp(kp), .ki(ki),
    .int_clear(int_clear), .int_hold(int_hold), .out_valid(ov[0]), .out(o[0]),
    .sat_hi(shi[0]), .sat_lo(slo[0]), .int_sat(isat[0])
  );

  pi_controller_aw #(.INT_LIM(1000)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .error(error), .kp(kp), .ki(ki),
    .int_clear(int_clear), .int_hold(int_hold), .out_valid(ov[1]), .out(o[1]),
    .sat_hi(shi[1]), .sat_lo(slo[1]), .int_sat(isat[1])
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct { longint p; longint i; } prod_t;
  prod_t  inflight[$];

  longint lim    [2] = '{(longint'(1) << 38) - 1, 1000};
  longint m_integ[2] = '{0, 0};
  longint m_out  [2] = '{0, 0};
  bit     m_ov   [2] = '{0, 0};
  bit     m_hi   [2] = '{0, 0};
  bit     m_lo   [2] = '{0, 0};

  task automatic model_edge(input bit v, input longint e, input longint gkp,
                            input longint gki, input bit clr, input bit hold,
                            input bit r);
    bit     have;
    prod_t  s;
    longint cand, inew, y;
    have = (inflight.size() > 0);
    if (have) s = inflight.pop_front();
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_integ[k] = 0; m_out[k] = 0; m_ov[k] = 0; m_hi[k] = 0; m_lo[k] = 0;
      end else if (have) begin
        cand = m_integ[k] + s.i;
        if (cand > lim[k])  cand = lim[k];
        if (cand < -lim[k]) cand = -lim[k];
        if (clr)                                           inew = 0;
        else if (hold || (m_hi[k] && s.i > 0) || (m_lo[k] && s.i < 0)) inew = m_integ[k];
        else                                               inew = cand;
        y = (s.p + inew) >>> 8;
        m_hi[k]  = (y > 32767);
        m_lo[k]  = (y < -32768);
        m_out[k] = m_hi[k] ? 32767 : (m_lo[k] ? -32768 : y);
        m_ov[k]  = 1;
        m_integ[k] = inew;
      end else begin
        m_ov[k] = 0;
        if (clr) m_integ[k] = 0;
      end
    end
    if (r) inflight.delete();
    else if (v) inflight.push_back('{p: e * gkp, i: e * gki});
  endtask

  // One clock: drive on the falling edge, step the model, sample 1 ns after
  // the rising edge and compare both instances.
  task automatic step(input bit v, input longint e, input longint gkp,
                      input longint gki, input bit clr = 0, input bit hold = 0,
                      input bit r = 0);
    @(negedge clk);
    rst       = r;
    in_valid  = v;
    error     = 16'(e);
    kp        = 16'(gkp);
    ki        = 16'(gki);
    int_clear = clr;
    int_hold  = hold;
    model_edge(v, e, gkp, gki, clr, hold, r);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("u%0d out_valid", k), longint'(ov[k]), longint'(m_ov[k]));
      check($sformatf("u%0d out", k), longint'(o[k]), m_out[k]);
      check($sformatf("u%0d sat_hi", k), longint'(shi[k]), longint'(m_hi[k]));
      check($sformatf("u%0d sat_lo", k), longint'(slo[k]), longint'(m_lo[k]));
      check($sformatf("u%0d int_sat", k), longint'(isat[k]),
            longint'(m_integ[k] == lim[k] || m_integ[k] == -lim[k]));
    end
  endtask

  initial begin
    longint e, gkp, gki;

    // Reset state
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    check("reset out_valid", longint'(ov[0]), 0);
    step(0, 0, 0, 0);

    // 1. proportional only
    step(1, 100, 256, 0);
    step(0, 0, 256, 0);
    check("t1 out", longint'(o[0]), 100);
    check("t1 out_valid", longint'(ov[0]), 1);
    step(0, 0, 256, 0);

    // 2. PI accumulation
    step(1, 100, 256, 128);
    step(1, 100, 256, 128);
    check("t2 out a", longint'(o[0]), 150);
    step(1, 100, 256, 128);
    check("t2 out b", longint'(o[0]), 200);
    step(0, 0, 256, 128);
    check("t2 out c", longint'(o[0]), 250);

    // 4. hold then clear (integrator is 38400 after test 2)
    step(1, 100, 256, 128, 0, 1);
    step(1, 100, 256, 128, 0, 1);
    check("t4 hold a", longint'(o[0]), 250);
    step(0, 0, 256, 128, 0, 1);
    check("t4 hold b", longint'(o[0]), 250);
    step(1, 100, 256, 128);
    step(0, 0, 256, 128, 1, 0);
    check("t4 clear", longint'(o[0]), 100);
    step(0, 0, 0, 0);

    // 3. output saturation and anti-windup
    for (int n = 0; n < 10; n++) step(1, 32767, 4096, 256);
    step(1, -1, 4096, 256);
    check("t3 sat out", longint'(o[0]), 32767);
    check("t3 sat_hi", longint'(shi[0]), 1);
    step(0, 0, 4096, 256);
    check("t3 recover out", longint'(o[0]), 32750);
    check("t3 recover sat_hi", longint'(shi[0]), 0);
    step(0, 0, 0, 0, 1, 0);

    // 5. integrator clamp on the small-limit instance
    for (int n = 0; n < 6; n++) step(1, 100, 0, 256);
    check("t5 int_sat hi", longint'(isat[1]), 1);
    for (int n = 0; n < 4; n++) step(1, -100, 0, 256);
    step(0, 0, 0, 256);
    check("t5 int_sat lo", longint'(isat[1]), 1);
    step(0, 0, 0, 0, 1, 0);

    // 6. reset one cycle after a sample
    step(1, 100, 256, 0);
    step(0, 0, 256, 0, 0, 0, 1);
    check("t6 no pulse", longint'(ov[0]), 0);
    check("t6 out zero", longint'(o[0]), 0);
    step(0, 0, 256, 0);
    step(1, 100, 256, 0);
    step(0, 0, 256, 0);
    check("t6 after reset", longint'(o[0]), 100);

    // Randomized stream
    for (int n = 0; n < 400; n++) begin
      e   = longint'($signed(16'($urandom)));
      gkp = ($urandom_range(0, 3) == 0) ? longint'($urandom_range(0, 65535))
                                        : longint'($urandom_range(0, 1024));
      gki = ($urandom_range(0, 3) == 0) ? longint'($urandom_range(0, 65535))
                                        : longint'($urandom_range(0, 512));
      step($urandom_range(0, 3) != 0, e, gkp, gki,
           $urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 99) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
